// File: rtl/dsa_fetch_unit_simd.sv
// Fetch stage for the SIMD bilinear datapath: maps an output group to source
// coordinates and gathers the four neighbour pixels per lane from a 1-cycle RAM.
module dsa_fetch_unit_simd #(
  parameter int SIMD_WIDTH = 4,
  parameter int ADDR_WIDTH = 18,
  parameter int FRAC_BITS  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_req,
  input  logic [15:0]                     base_x,
  input  logic [15:0]                     base_y,
  input  logic [15:0]                     img_width_in,
  input  logic [15:0]                     img_height_in,
  input  logic [15:0]                     img_width_out,
  input  logic [15:0]                     scale_x,
  input  logic [15:0]                     scale_y,
  output logic                            mem_rd,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [7:0]                      mem_rdata,
  output logic [SIMD_WIDTH*32-1:0]        pix_out,
  output logic [SIMD_WIDTH*FRAC_BITS-1:0] frac_x,
  output logic [FRAC_BITS-1:0]            frac_y,
  output logic [SIMD_WIDTH-1:0]           lane_valid,
  output logic                            fetch_done,
  output logic                            busy
);

  localparam int NSLOT  = 4 * SIMD_WIDTH;
  localparam int LANE_W = (SIMD_WIDTH > 1) ? $clog2(SIMD_WIDTH) : 1;
  localparam int CNT_W  = LANE_W + 2;
  localparam int PW     = 16 + FRAC_BITS;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0] bx_q, bx_d, by_q, by_d, w_q, w_d, h_q, h_d, wout_q, wout_d;
  logic [15:0] sclx_q, sclx_d, scly_q, scly_d;
  logic [SIMD_WIDTH-1:0][15:0] x0_q, x0_d, x1_q, x1_d;
  logic [15:0] y0_q, y0_d, y1_q, y1_d;
  logic [SIMD_WIDTH-1:0][FRAC_BITS-1:0] frac_x_q, frac_x_d;
  logic [FRAC_BITS-1:0] frac_y_q, frac_y_d;
  logic [SIMD_WIDTH-1:0] lane_valid_q, lane_valid_d;
  logic [NSLOT-1:0][7:0] pix_q, pix_d;
  logic cap_en_q, cap_en_d, cap_valid_q, cap_valid_d;
  logic [CNT_W-1:0] cap_idx_q, cap_idx_d;
  logic fetch_done_q, fetch_done_d, busy_q, busy_d;

  function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [15:0] clamp_inc(input logic [15:0] v, input logic [15:0] mx);
    return (v >= mx) ? mx : v + 16'd1;
  endfunction

  // A zero-sized image collapses every coordinate onto pixel 0.
  logic [15:0] wmax, hmax;
  assign wmax = (w_q == 16'd0) ? 16'd0 : w_q - 16'd1;
  assign hmax = (h_q == 16'd0) ? 16'd0 : h_q - 16'd1;

  logic [SIMD_WIDTH-1:0][15:0] x0_c, x1_c;
  logic [SIMD_WIDTH-1:0][FRAC_BITS-1:0] fx_c;
  logic [SIMD_WIDTH-1:0] lv_c;

  for (genvar gi = 0; gi < SIMD_WIDTH; gi++) begin : g_lane
    logic [31:0]   ox;
    logic [PW-1:0] prod;
    assign ox       = {16'd0, bx_q} + 32'(gi);
    assign prod     = PW'(ox * {16'd0, sclx_q});
    assign x0_c[gi] = clamp(prod[FRAC_BITS +: 16], wmax);
    assign x1_c[gi] = clamp_inc(x0_c[gi], wmax);
    assign fx_c[gi] = prod[FRAC_BITS-1:0];
    assign lv_c[gi] = ox < {16'd0, wout_q};
  end

  logic [PW-1:0] prod_y;
  logic [15:0]   y0_c;
  assign prod_y = PW'({16'd0, by_q} * {16'd0, scly_q});
  assign y0_c   = clamp(prod_y[FRAC_BITS +: 16], hmax);

  // Slot k = lane*4 + neighbour; neighbour bit0 selects x1, bit1 selects y1.
  logic [LANE_W-1:0] lane_idx;
  logic [15:0]       x_sel, y_sel;
  assign lane_idx = cnt_q[CNT_W-1:2];
  assign x_sel    = cnt_q[0] ? x1_q[lane_idx] : x0_q[lane_idx];
  assign y_sel    = cnt_q[1] ? y1_q : y0_q;

  assign mem_rd   = (state_q == S_ISSUE) && lane_valid_q[lane_idx];
  assign mem_addr = (state_q == S_ISSUE)
                  ? ADDR_WIDTH'({16'd0, y_sel} * {16'd0, w_q} + {16'd0, x_sel})
                  : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bx_d         = bx_q;
    by_d         = by_q;
    w_d          = w_q;
    h_d          = h_q;
    wout_d       = wout_q;
    sclx_d       = sclx_q;
    scly_d       = scly_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    y0_d         = y0_q;
    y1_d         = y1_q;
    frac_x_d     = frac_x_q;
    frac_y_d     = frac_y_q;
    lane_valid_d = lane_valid_q;
    pix_d        = pix_q;

    case (state_q)
      S_IDLE: begin
        if (fetch_req) begin
          bx_d    = base_x;
          by_d    = base_y;
          w_d     = img_width_in;
          h_d     = img_height_in;
          wout_d  = img_width_out;
          sclx_d  = scale_x;
          scly_d  = scale_y;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        x0_d         = x0_c;
        x1_d         = x1_c;
        y0_d         = y0_c;
        y1_d         = clamp_inc(y0_c, hmax);
        frac_x_d     = fx_c;
        frac_y_d     = prod_y[FRAC_BITS-1:0];
        lane_valid_d = lv_c;
        cnt_d        = '0;
        state_d      = S_ISSUE;
      end
      S_ISSUE: begin
        if (cnt_q == CNT_W'(NSLOT - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // RAM data returns one cycle after the strobe; skipped lanes capture zero.
    cap_en_d    = (state_q == S_ISSUE);
    cap_idx_d   = cnt_q;
    cap_valid_d = mem_rd;
    if (cap_en_q) begin
      pix_d[cap_idx_q] = cap_valid_q ? mem_rdata : 8'd0;
    end

    fetch_done_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      wout_q       <= '0;
      sclx_q       <= '0;
      scly_q       <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      y0_q         <= '0;
      y1_q         <= '0;
      frac_x_q     <= '0;
      frac_y_q     <= '0;
      lane_valid_q <= '0;
      pix_q        <= '0;
      cap_en_q     <= 1'b0;
      cap_idx_q    <= '0;
      cap_valid_q  <= 1'b0;
      fetch_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      w_q          <= w_d;
      h_q          <= h_d;
      wout_q       <= wout_d;
      sclx_q       <= sclx_d;
      scly_q       <= scly_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      y0_q         <= y0_d;
      y1_q         <= y1_d;
      frac_x_q     <= frac_x_d;
      frac_y_q     <= frac_y_d;
      lane_valid_q <= lane_valid_d;
      pix_q        <= pix_d;
      cap_en_q     <= cap_en_d;
      cap_idx_q    <= cap_idx_d;
      cap_valid_q  <= cap_valid_d;
      fetch_done_q <= fetch_done_d;
      busy_q       <= busy_d;
    end
  end

  assign pix_out    = pix_q;
  assign frac_x     = frac_x_q;
  assign frac_y     = frac_y_q;
  assign lane_valid = lane_valid_q;
  assign fetch_done = fetch_done_q;
  assign busy       = busy_q;

endmodule

// File: doc/dsa_fetch_unit_simd.md
Name: dsa_fetch_unit_simd

Overview:
- Fetch stage feeding the SIMD bilinear datapath; handshakes with the SIMD control FSM through fetch_req/fetch_done.
- For an output group (base_x..base_x+SIMD_WIDTH-1, base_y), computes fixed-point source coordinates per lane.
- Reads the four neighbour pixels per lane from a synchronous 8-bit source RAM, one read per cycle.
- Presents pixels, fractional weights and lane-valid flags to the datapath.

Parameters:
- SIMD_WIDTH, 4, lanes per group (1..8).
- ADDR_WIDTH, 18, source RAM address width.
- FRAC_BITS, 8, fractional bits of the scale factors and weights (fixed at 8 for this revision).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- fetch_req  in  1  single-cycle start request.
- base_x  in  16  output x of lane 0.
- base_y  in  16  output y of the group.
- img_width_in  in  16  source width W.
- img_height_in  in  16  source height H.
- img_width_out  in  16  output width; used for lane validity.
- scale_x  in  16  Q8.8 source step per output pixel in x.
- scale_y  in  16  Q8.8 source step per output pixel in y.
- mem_rd  out  1  read strobe.
- mem_addr  out  ADDR_WIDTH  read address.
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd.
- pix_out  out  SIMD_WIDTH*32  per lane {p11,p10,p01,p00}; lane i at bits [32i+31:32i], p00 in the LSB.
- frac_x  out  SIMD_WIDTH*8  per-lane x weight.
- frac_y  out  8  common y weight.
- lane_valid  out  SIMD_WIDTH  bit i set when base_x+i < img_width_out.
- fetch_done  out  1  single-cycle completion pulse.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, any time including mid-fetch):
  - state goes to IDLE.
  - All outputs go to 0: mem_rd, mem_addr, pix_out, frac_x, frac_y, lane_valid, fetch_done, busy.
  - Issue counter goes to 0.
- States and transitions:
  - IDLE → CALC on fetch_req.
  - CALC → ISSUE after 1 cycle.
  - ISSUE → DRAIN after 4*SIMD_WIDTH cycles.
  - DRAIN → DONE after 1 cycle.
  - DONE → IDLE after 1 cycle.
- fetch_req outside IDLE is ignored; there is no queueing.
- IDLE accepts fetch_req:
  - Latches all inputs. The latched copies are used until the next accept.
  - Input changes mid-fetch have no effect.
- CALC registers per-lane coordinates:
  - ox = base_x + i.
  - sx = ox * scale_x, 32-bit unsigned.
  - x0 = sx[23:8], frac_x lane = sx[7:0].
  - Clamp x0 to W-1.
  - x1 = min(x0+1, W-1).
  - y is computed identically with base_y and scale_y, using H-1, giving y0, y1 and frac_y.
  - If W=0 or H=0, clamp limits are treated as 0.
  - lane_valid is registered in CALC.
- ISSUE runs counter k = 0..4*SIMD_WIDTH-1:
  - lane = k/4, neighbour = k%4, order p00(y0,x0), p01(y0,x1), p10(y1,x0), p11(y1,x1).
  - mem_addr = y*W + x, truncated to ADDR_WIDTH.
  - mem_rd = lane_valid[lane].
  - For invalid lanes mem_rd stays 0, the counter still advances, and slot data is written as 0.
  - Latency is therefore fixed at 4*SIMD_WIDTH+3 cycles regardless of validity.
- Capture: mem_rdata is written into its slot one cycle after issue. The final capture happens in DRAIN.
- DONE: fetch_done = 1 for exactly one cycle.
- Timing: fetch_done is high in cycle 4*SIMD_WIDTH+3 after the fetch_req accept edge (19 for SIMD_WIDTH=4).
- Output hold:
  - pix_out, frac_x, frac_y and lane_valid hold their values from DONE until the CALC of the next accepted request.
  - pix_out slots are overwritten progressively during ISSUE/DRAIN.
- fetch_req arriving in the same cycle as DONE is ignored. Back-to-back requests are accepted from IDLE only.

Test Plan:
Common setup unless stated: mem[a] = a & 0xFF; W=8, H=8; img_width_out=16; scale_x = scale_y = 0x0080.
- Reset → all outputs 0, busy=0. Assert rst during ISSUE → next cycle mem_rd=0, busy=0; a later fetch_req completes normally.
- base_x=4, base_y=3:
  - frac_x = {80,00,80,00} (lane3..0), frac_y=0x80.
  - Lane1 pix = {19,18,11,10}; lane0 pix = {19,18,11,10}.
  - fetch_done exactly 19 cycles after the accept edge, one cycle wide.
- base_x=12, base_y=15:
  - Lane3 x0=7, x1=7, y0=7, y1=7 (clamped).
  - Lane3 pix = {63,63,63,63}.
- img_width_out=6, base_x=4: lane_valid=0011; exactly 8 mem_rd pulses; lanes 2-3 pix=0; fetch_done still at cycle 19.
- fetch_req pulsed during ISSUE and during DONE → ignored: no second fetch_done, outputs unchanged.
- W=0, H=0 → all addresses 0, lane_valid unaffected, completes in 19 cycles.
